// File: rtl/obj_motion_pkg.sv
// Shared dimensions, signed datapath widths, retire reason codes and launcher
// state encoding for the fruit object motion blocks.
package obj_motion_pkg;

  localparam int WINDOW_WIDTH_DEF  = 640;
  localparam int WINDOW_HEIGHT_DEF = 480;
  localparam int OBJ_W_DEF         = 64;
  localparam int OBJ_H_DEF         = 64;

  localparam int X_W  = 11;
  localparam int Y_W  = 10;
  localparam int VY_W = 7;

  typedef enum logic [1:0] {
    REASON_FELL = 2'd0,
    REASON_SIDE = 2'd1,
    REASON_TOP  = 2'd2,
    REASON_KILL = 2'd3
  } reason_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLY    = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

endpackage

// File: rtl/object_kinematics_step.sv
// One frame of ballistic motion plus the playfield exit check; purely combinational.
// No state and no backpressure: outputs follow the inputs within the same cycle.
module object_kinematics_step
  import obj_motion_pkg::*;
#(
  parameter int WINDOW_WIDTH  = WINDOW_WIDTH_DEF,
  parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
  parameter int OBJ_W         = OBJ_W_DEF,
  parameter int OBJ_H         = OBJ_H_DEF,
  parameter int GRAVITY       = 1,
  parameter int VY_MAX        = 31
) (
  input  logic [9:0]             x_i,
  input  logic [8:0]             y_i,
  input  logic signed [3:0]      vx_i,
  input  logic signed [VY_W-1:0] vy_i,
  input  logic                   grav_en_i,
  output logic signed [X_W-1:0]  x_n_o,
  output logic signed [Y_W-1:0]  y_n_o,
  output logic signed [VY_W-1:0] vy_n_o,
  output logic                   exit_o,
  output reason_e                reason_o
);

  localparam logic signed [X_W-1:0]  X_MAX  = X_W'(WINDOW_WIDTH - OBJ_W);
  localparam logic signed [Y_W-1:0]  Y_MAX  = Y_W'(WINDOW_HEIGHT - OBJ_H);
  localparam logic signed [VY_W:0]   VY_LIM = (VY_W+1)'(VY_MAX);
  localparam logic signed [VY_W:0]   G_INC  = (VY_W+1)'(GRAVITY);

  logic signed [VY_W:0] vy_sum;
  logic                 vy_down;

  always_comb begin
    x_n_o    = {{(X_W-10){1'b0}}, x_i} + {{(X_W-4){vx_i[3]}}, vx_i};
    y_n_o    = {{(Y_W-9){1'b0}}, y_i} + {{(Y_W-VY_W){vy_i[VY_W-1]}}, vy_i};
    vy_sum   = {vy_i[VY_W-1], vy_i} + G_INC;
    vy_down  = !vy_i[VY_W-1] && (vy_i != '0);
    vy_n_o   = vy_i;
    if (grav_en_i) begin
      vy_n_o = (vy_sum > VY_LIM) ? VY_LIM[VY_W-1:0] : vy_sum[VY_W-1:0];
    end
    // Priority: side edges, then top, then falling back through the spawn line.
    exit_o   = 1'b1;
    reason_o = REASON_SIDE;
    if (x_n_o[X_W-1] || (x_n_o > X_MAX)) begin
      reason_o = REASON_SIDE;
    end else if (y_n_o[Y_W-1]) begin
      reason_o = REASON_TOP;
    end else if (vy_down && (y_n_o > Y_MAX)) begin
      reason_o = REASON_FELL;
    end else begin
      exit_o   = 1'b0;
      reason_o = REASON_FELL;
    end
  end

endmodule

// File: rtl/object_launcher.sv
// Spawns one object at the bottom edge and steps it along a parabola per frame_tick;
// launch accepted in IDLE only (1 cycle to FLY), requests outside IDLE are dropped.
module object_launcher
  import obj_motion_pkg::*;
#(
  parameter int WINDOW_WIDTH  = WINDOW_WIDTH_DEF,
  parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
  parameter int OBJ_W         = OBJ_W_DEF,
  parameter int OBJ_H         = OBJ_H_DEF,
  parameter int GRAVITY       = 1,
  parameter int GRAV_DIV      = 1,
  parameter int VY_MAX        = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       launch_valid,
  output logic       launch_ready,
  input  logic [9:0] launch_x,
  input  logic [3:0] launch_vx,
  input  logic [5:0] launch_vy,
  input  logic       kill,
  output logic       active,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       retire_pulse,
  output logic [1:0] retire_reason
);

  localparam logic [9:0] X_SPAWN_MAX = 10'(WINDOW_WIDTH - OBJ_W);
  localparam logic [8:0] Y_SPAWN     = 9'(WINDOW_HEIGHT - OBJ_H);

  state_e                state_q;
  logic [9:0]            x_q;
  logic [8:0]            y_q;
  logic signed [3:0]     vx_q;
  logic signed [VY_W-1:0] vy_q;
  logic [3:0]            grav_q;
  logic                  active_q;
  logic                  ready_q;
  logic                  pulse_q;
  reason_e               reason_q;

  logic [9:0]             x_spawn_d;
  logic [3:0]             grav_d;
  logic                   grav_en_d;
  logic signed [X_W-1:0]  x_n;
  logic signed [Y_W-1:0]  y_n;
  logic signed [VY_W-1:0] vy_n;
  logic                   exit_n;
  reason_e                reason_n;
  logic                   unused_msb;

  assign x_spawn_d  = (launch_x > X_SPAWN_MAX) ? X_SPAWN_MAX : launch_x;
  assign grav_d     = grav_q + 4'd1;
  assign grav_en_d  = (grav_d == 4'(GRAV_DIV));
  assign unused_msb = x_n[X_W-1] ^ y_n[Y_W-1];

  object_kinematics_step #(
    .WINDOW_WIDTH (WINDOW_WIDTH),
    .WINDOW_HEIGHT(WINDOW_HEIGHT),
    .OBJ_W        (OBJ_W),
    .OBJ_H        (OBJ_H),
    .GRAVITY      (GRAVITY),
    .VY_MAX       (VY_MAX)
  ) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .vx_i     (vx_q),
    .vy_i     (vy_q),
    .grav_en_i(grav_en_d),
    .x_n_o    (x_n),
    .y_n_o    (y_n),
    .vy_n_o   (vy_n),
    .exit_o   (exit_n),
    .reason_o (reason_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      grav_q   <= '0;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
      pulse_q  <= 1'b0;
      reason_q <= REASON_FELL;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (launch_valid) begin
            x_q      <= x_spawn_d;
            y_q      <= Y_SPAWN;
            vx_q     <= launch_vx;
            vy_q     <= {launch_vy[5], launch_vy};
            grav_q   <= '0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= ST_FLY;
          end
        end
        ST_FLY: begin
          // A slice hit outranks any geometric exit in the same cycle.
          if (kill) begin
            active_q <= 1'b0;
            pulse_q  <= 1'b1;
            reason_q <= REASON_KILL;
            state_q  <= ST_RETIRE;
          end else if (frame_tick) begin
            if (exit_n) begin
              active_q <= 1'b0;
              pulse_q  <= 1'b1;
              reason_q <= reason_n;
              state_q  <= ST_RETIRE;
            end else begin
              x_q    <= x_n[9:0];
              y_q    <= y_n[8:0];
              vy_q   <= vy_n;
              grav_q <= grav_en_d ? 4'd0 : grav_d;
            end
          end
        end
        ST_RETIRE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          active_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign launch_ready  = ready_q;
  assign active        = active_q;
  assign posx          = x_q;
  assign posy          = y_q;
  assign retire_pulse  = pulse_q;
  assign retire_reason = reason_q;

endmodule

// File: tb/tb_object_launcher.sv
// Bench for object_launcher: directed flights plus random traffic, every cycle
// compared against an integer-arithmetic flight model.
module tb_object_launcher;

  localparam int XMAX = 576;
  localparam int YSPAWN = 416;
  localparam int GRAV = 1;
  localparam int GDIV = 1;
  localparam int VYMAX = 31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       launch_valid = 1'b0;
  logic       launch_ready;
  logic [9:0] launch_x = '0;
  logic [3:0] launch_vx = '0;
  logic [5:0] launch_vy = '0;
  logic       kill = 1'b0;
  logic       active;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       retire_pulse;
  logic [1:0] retire_reason;

  int errors = 0;
  int checks = 0;

  // Reference model: flight status plus integer position/velocity
  bit m_flying, m_retiring;
  int m_x, m_y, m_vx, m_vy, m_cnt, m_act, m_rdy, m_pulse, m_reason;

  always #5 clk = ~clk;

  object_launcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .launch_x     (launch_x),
    .launch_vx    (launch_vx),
    .launch_vy    (launch_vy),
    .kill         (kill),
    .active       (active),
    .posx         (posx),
    .posy         (posy),
    .retire_pulse (retire_pulse),
    .retire_reason(retire_reason)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flying = 0; m_retiring = 0;
    m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_cnt = 0;
    m_act = 0; m_rdy = 1; m_pulse = 0; m_reason = 0;
  endtask

  task automatic model_retire(input int r);
    m_flying = 0; m_retiring = 1; m_act = 0; m_pulse = 1; m_reason = r;
  endtask

  task automatic model_step();
    int xn, yn, r;
    m_pulse = 0;
    if (m_retiring) begin
      m_retiring = 0; m_rdy = 1;
    end else if (m_flying) begin
      if (kill) model_retire(3);
      else if (frame_tick) begin
        xn = m_x + m_vx;
        yn = m_y + m_vy;
        r = -1;
        if (xn < 0 || xn > XMAX) r = 1;
        else if (yn < 0) r = 2;
        else if (m_vy > 0 && yn > YSPAWN) r = 0;
        if (r >= 0) model_retire(r);
        else begin
          m_x = xn; m_y = yn;
          m_cnt++;
          if (m_cnt == GDIV) begin
            m_cnt = 0;
            m_vy = (m_vy + GRAV > VYMAX) ? VYMAX : m_vy + GRAV;
          end
        end
      end
    end else if (launch_valid) begin
      m_x = (int'(launch_x) > XMAX) ? XMAX : int'(launch_x);
      m_y = YSPAWN;
      m_vx = $signed(launch_vx);
      m_vy = $signed(launch_vy);
      m_cnt = 0; m_flying = 1; m_act = 1; m_rdy = 0;
    end
  endtask

  task automatic compare_all();
    check("active", active, m_act);
    check("posx", posx, m_x);
    check("posy", posy, m_y);
    check("retire_pulse", retire_pulse, m_pulse);
    check("launch_ready", launch_ready, m_rdy);
    if (m_pulse != 0) check("retire_reason", retire_reason, m_reason);
    if (active) begin
      check("inv_posx", posx <= XMAX, 1);
      check("inv_posy", posy <= YSPAWN, 1);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_launch(input int x, input int vx, input int vy);
    launch_valid = 1'b1;
    launch_x = x[9:0];
    launch_vx = vx[3:0];
    launch_vy = vy[5:0];
    step();
    launch_valid = 1'b0;
  endtask

  task automatic do_tick(input bit k);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) step();
    frame_tick = 1'b1;
    kill = k;
    step();
    frame_tick = 1'b0;
    kill = 1'b0;
  endtask

  initial begin
    bit done;
    model_reset();
    #12;
    check("rst_active", active, 0);
    check("rst_posx", posx, 0);
    check("rst_posy", posy, 0);
    check("rst_pulse", retire_pulse, 0);
    check("rst_reason", retire_reason, 0);
    check("rst_ready", launch_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Slice hit with nothing in flight
    kill = 1'b1;
    step();
    check("idle_kill_pulse", retire_pulse, 0);
    kill = 1'b0;
    step();

    // Parabola back through the spawn line
    do_launch(100, 2, -12);
    check("para_spawn_x", posx, 100);
    check("para_spawn_y", posy, 416);
    for (int t = 1; t <= 26; t++) begin
      do_tick(1'b0);
      if (t == 1) check("para_y1", posy, 404);
      if (t == 12) check("para_y12", posy, 338);
      if (t == 13) check("para_y13", posy, 338);
      if (t == 25) begin
        check("para_y25", posy, 416);
        check("para_x25", posx, 150);
      end
      if (t == 26) begin
        check("para_fell_pulse", retire_pulse, 1);
        check("para_fell_reason", retire_reason, 0);
        check("para_hold_x", posx, 150);
        check("para_hold_y", posy, 416);
      end
    end
    step();
    check("para_ready_back", launch_ready, 1);

    // Side exit
    do_launch(560, 7, -10);
    for (int t = 1; t <= 3; t++) begin
      do_tick(1'b0);
      if (t == 1) check("side_x1", posx, 567);
      if (t == 2) check("side_x2", posx, 574);
    end
    check("side_reason", retire_reason, 1);
    check("side_hold_x", posx, 574);
    step();

    // Kill on the same tick as the side exit
    do_launch(560, 7, -10);
    do_tick(1'b0);
    do_tick(1'b0);
    do_tick(1'b1);
    check("kill_pulse", retire_pulse, 1);
    check("kill_reason", retire_reason, 3);
    step();

    // Exit through the top
    do_launch(300, 0, -32);
    done = 0;
    for (int t = 1; t <= 40 && !done; t++) begin
      do_tick(1'b0);
      if (t == 1) check("top_y1", posy, 384);
      if (retire_pulse) done = 1;
    end
    check("top_pulse_seen", done, 1);
    check("top_reason", retire_reason, 2);
    step();

    // Clamped spawn, launch_valid held through the whole flight
    launch_valid = 1'b1; launch_x = 10'd700; launch_vx = 4'd0; launch_vy = 6'h3b;
    step();
    check("clamp_x", posx, 576);
    step(); step(); step();
    check("held_not_ready", launch_ready, 0);
    kill = 1'b1; step(); kill = 1'b0;
    step();
    check("ready_after_retire", launch_ready, 1);
    step();
    check("relaunch_active", active, 1);
    launch_valid = 1'b0;
    kill = 1'b1; step(); kill = 1'b0;
    step();

    // Asynchronous reset mid-flight
    do_launch(100, 2, -12);
    for (int t = 1; t <= 5; t++) do_tick(1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_active", active, 0);
    check("arst_posx", posx, 0);
    check("arst_posy", posy, 0);
    check("arst_pulse", retire_pulse, 0);
    check("arst_ready", launch_ready, 1);
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      launch_valid = ($urandom_range(0, 3) == 0);
      launch_x = 10'($urandom_range(0, 1023));
      launch_vx = 4'($urandom);
      launch_vy = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom);
      frame_tick = ($urandom_range(0, 2) == 0);
      kill = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
